// File: rtl/coeff_bram_mp_if.sv
// rtl/coeff_bram_mp_if.sv - access bundle for the dual-port coefficient RAM
// The master side belongs to the NTT controller or butterfly units, and the slave side belongs to the RAM.
interface coeff_bram_mp_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int WIDTH      = 32
);
   logic                  clr_req;
   logic                  busy;

   logic                  en_a;
   logic                  we_a;
   logic [ADDR_WIDTH-1:0] waddr_a;
   logic [ADDR_WIDTH-1:0] raddr_a;
   logic [WIDTH-1:0]      din_a;
   logic [WIDTH-1:0]      dout_a;
   logic                  dout_vld_a;

   logic                  en_b;
   logic                  we_b;
   logic [ADDR_WIDTH-1:0] waddr_b;
   logic [ADDR_WIDTH-1:0] raddr_b;
   logic [WIDTH-1:0]      din_b;
   logic [WIDTH-1:0]      dout_b;
   logic                  dout_vld_b;

   logic                  collision;
   logic [ADDR_WIDTH-1:0] dbg_raddr;
   logic [WIDTH-1:0]      dbg_rdata;

   modport master (
      output clr_req,
      output en_a, we_a, waddr_a, raddr_a, din_a,
      output en_b, we_b, waddr_b, raddr_b, din_b,
      output dbg_raddr,
      input  busy,
      input  dout_a, dout_vld_a,
      input  dout_b, dout_vld_b,
      input  collision,
      input  dbg_rdata
   );

   modport slave (
      input  clr_req,
      input  en_a, we_a, waddr_a, raddr_a, din_a,
      input  en_b, we_b, waddr_b, raddr_b, din_b,
      input  dbg_raddr,
      output busy,
      output dout_a, dout_vld_a,
      output dout_b, dout_vld_b,
      output collision,
      output dbg_rdata
   );
endinterface

// File: rtl/coeff_bram_mp.sv
// rtl/coeff_bram_mp.sv - dual-port coefficient RAM with clear sequencer and debug read port
// A clear sequencer initialises the array, so the array itself has no reset.
module coeff_bram_mp #(
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int WIDTH      = 32,
   parameter int RD_LAT     = 1,
   parameter int RDW_MODE   = 0
) (
   input logic             clk,
   input logic             rst_n,
   coeff_bram_mp_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      CLR  = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] clr_ptr;
   logic [ADDR_WIDTH-1:0] clr_ptr_nxt;
   logic                  busy;

   logic                  wr_a;
   logic                  wr_b;
   logic                  rd_a;
   logic                  rd_b;
   logic [WIDTH-1:0]      rdata_a;
   logic [WIDTH-1:0]      rdata_b;
   logic [WIDTH-1:0]      rdata_dbg;

   logic [WIDTH-1:0]      mem [DEPTH];

   logic                  s1_vld_a;
   logic                  s1_vld_b;
   logic [WIDTH-1:0]      s1_data_a;
   logic [WIDTH-1:0]      s1_data_b;
   logic                  collision_q;
   logic [WIDTH-1:0]      dbg_rdata_q;

   assign busy = (state == CLR);

   // Port traffic is suppressed for the whole clear, including the edge that writes the last word.
   assign wr_a = ~busy & bus.en_a & bus.we_a;
   assign wr_b = ~busy & bus.en_b & bus.we_b;
   assign rd_a = ~busy & bus.en_a;
   assign rd_b = ~busy & bus.en_b;

   // Clear sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLR;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      case (state)
         IDLE: begin
            if (bus.clr_req) begin
               state_nxt   = CLR;
               clr_ptr_nxt = '0;
            end
         end
         CLR: begin
            if (clr_ptr == LAST_ADDR) begin
               state_nxt   = IDLE;
               clr_ptr_nxt = '0;
            end else begin
               clr_ptr_nxt = clr_ptr + 1'b1;
            end
         end
         default: begin
            state_nxt   = CLR;
            clr_ptr_nxt = '0;
         end
      endcase
   end

   // Storage: port A is written last, so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_ptr] <= '0;
      end else begin
         if (wr_b) begin
            mem[bus.waddr_b] <= bus.din_b;
         end
         if (wr_a) begin
            mem[bus.waddr_a] <= bus.din_a;
         end
      end
   end

   // Returns the word a read observes. In write-first mode, a same-edge write is forwarded with the same priority as storage.
   function automatic logic [WIDTH-1:0] resolve_read(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [WIDTH-1:0]      raw,
      input logic                  clr_en,
      input logic [ADDR_WIDTH-1:0] clr_addr,
      input logic                  wa,
      input logic [ADDR_WIDTH-1:0] wa_addr,
      input logic [WIDTH-1:0]      wa_data,
      input logic                  wb,
      input logic [ADDR_WIDTH-1:0] wb_addr,
      input logic [WIDTH-1:0]      wb_data
   );
      logic [WIDTH-1:0] result;
      result = raw;
      if (RDW_MODE == 1) begin
         if (clr_en && (clr_addr == addr)) begin
            result = '0;
         end else if (wa && (wa_addr == addr)) begin
            result = wa_data;
         end else if (wb && (wb_addr == addr)) begin
            result = wb_data;
         end
      end
      return result;
   endfunction

   always_comb begin
      rdata_a = resolve_read(bus.raddr_a, mem[bus.raddr_a], busy, clr_ptr,
                             wr_a, bus.waddr_a, bus.din_a,
                             wr_b, bus.waddr_b, bus.din_b);
   end

   always_comb begin
      rdata_b = resolve_read(bus.raddr_b, mem[bus.raddr_b], busy, clr_ptr,
                             wr_a, bus.waddr_a, bus.din_a,
                             wr_b, bus.waddr_b, bus.din_b);
   end

   always_comb begin
      rdata_dbg = resolve_read(bus.dbg_raddr, mem[bus.dbg_raddr], busy, clr_ptr,
                               wr_a, bus.waddr_a, bus.din_a,
                               wr_b, bus.waddr_b, bus.din_b);
   end

   // First read stage. The data registers hold when no read is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_a    <= 1'b0;
         s1_vld_b    <= 1'b0;
         s1_data_a   <= '0;
         s1_data_b   <= '0;
         collision_q <= 1'b0;
         dbg_rdata_q <= '0;
      end else begin
         s1_vld_a    <= rd_a;
         s1_vld_b    <= rd_b;
         if (rd_a) begin
            s1_data_a <= rdata_a;
         end
         if (rd_b) begin
            s1_data_b <= rdata_b;
         end
         collision_q <= wr_a & wr_b & (bus.waddr_a == bus.waddr_b);
         dbg_rdata_q <= rdata_dbg;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic             s2_vld_a;
         logic             s2_vld_b;
         logic [WIDTH-1:0] s2_data_a;
         logic [WIDTH-1:0] s2_data_b;

         // The second stage is not gated by busy, so reads in flight when a clear starts still complete.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_vld_a  <= 1'b0;
               s2_vld_b  <= 1'b0;
               s2_data_a <= '0;
               s2_data_b <= '0;
            end else begin
               s2_vld_a <= s1_vld_a;
               s2_vld_b <= s1_vld_b;
               if (s1_vld_a) begin
                  s2_data_a <= s1_data_a;
               end
               if (s1_vld_b) begin
                  s2_data_b <= s1_data_b;
               end
            end
         end

         assign bus.dout_a     = s2_data_a;
         assign bus.dout_b     = s2_data_b;
         assign bus.dout_vld_a = s2_vld_a;
         assign bus.dout_vld_b = s2_vld_b;
      end else begin : g_lat1
         assign bus.dout_a     = s1_data_a;
         assign bus.dout_b     = s1_data_b;
         assign bus.dout_vld_a = s1_vld_a;
         assign bus.dout_vld_b = s1_vld_b;
      end
   endgenerate

   assign bus.busy      = busy;
   assign bus.collision = collision_q;
   assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_coeff_bram_mp.sv
// tb/tb_coeff_bram_mp.sv - scoreboard bench for coeff_bram_mp
// dut0 is built with RD_LAT=1 and RDW_MODE=0, and dut1 with RD_LAT=2 and RDW_MODE=1. Both receive identical stimulus.
module tb_coeff_bram_mp;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Scoreboard index 0/1 = dut0 ports A/B, 2/3 = dut1 ports A/B
   logic [31:0] exp_q [4][$];
   int          due_q [4][$];

   always #5 clk = ~clk;

   coeff_bram_mp_if #(.ADDR_WIDTH(8), .WIDTH(32)) if0 ();
   coeff_bram_mp_if #(.ADDR_WIDTH(8), .WIDTH(32)) if1 ();

   coeff_bram_mp #(.DEPTH(256), .WIDTH(32), .RD_LAT(1), .RDW_MODE(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   coeff_bram_mp #(.DEPTH(256), .WIDTH(32), .RD_LAT(2), .RDW_MODE(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_port(input int p, input logic vld, input logic [31:0] d);
      if (vld) begin
         if (exp_q[p].size() == 0) begin
            chk($sformatf("unexpected_vld_p%0d_cyc%0d", p, cyc), 32'(vld), 32'd0);
         end else begin
            chk($sformatf("rdata_p%0d_cyc%0d", p, cyc), d, exp_q[p].pop_front());
            chk($sformatf("rd_latency_p%0d", p), cyc, due_q[p].pop_front());
         end
      end else if (exp_q[p].size() != 0 && due_q[p][0] <= cyc) begin
         chk($sformatf("missing_vld_p%0d_cyc%0d", p, cyc), 32'(vld), 32'd1);
         void'(exp_q[p].pop_front());
         void'(due_q[p].pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      check_port(0, if0.dout_vld_a, if0.dout_a);
      check_port(1, if0.dout_vld_b, if0.dout_b);
      check_port(2, if1.dout_vld_a, if1.dout_a);
      check_port(3, if1.dout_vld_b, if1.dout_b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_a(input logic en, input logic we, input logic [7:0] wa, input logic [7:0] ra, input logic [31:0] d);
      if0.en_a = en; if0.we_a = we; if0.waddr_a = wa; if0.raddr_a = ra; if0.din_a = d;
      if1.en_a = en; if1.we_a = we; if1.waddr_a = wa; if1.raddr_a = ra; if1.din_a = d;
   endtask

   task automatic set_b(input logic en, input logic we, input logic [7:0] wa, input logic [7:0] ra, input logic [31:0] d);
      if0.en_b = en; if0.we_b = we; if0.waddr_b = wa; if0.raddr_b = ra; if0.din_b = d;
      if1.en_b = en; if1.we_b = we; if1.waddr_b = wa; if1.raddr_b = ra; if1.din_b = d;
   endtask

   task automatic set_misc(input logic clr, input logic [7:0] dbg);
      if0.clr_req = clr; if0.dbg_raddr = dbg;
      if1.clr_req = clr; if1.dbg_raddr = dbg;
   endtask

   // Queue an expected read result. side 0 = A, 1 = B. exp0 is for old-data mode, exp1 for write-first mode.
   task automatic push_rd(input int side, input logic [31:0] exp0, input logic [31:0] exp1);
      exp_q[side].push_back(exp0);
      due_q[side].push_back(cyc + 1);
      exp_q[side + 2].push_back(exp1);
      due_q[side + 2].push_back(cyc + 2);
   endtask

   task automatic wait_clear(input string tag);
      int n0 = 0;
      int n1 = 0;
      for (int i = 1; i <= 1000 && (n0 == 0 || n1 == 0); i++) begin
         tick();
         if (!if0.busy && n0 == 0) n0 = i;
         if (!if1.busy && n1 == 0) n1 = i;
      end
      chk({tag, "_dut0"}, 32'(n0), 32'd256);
      chk({tag, "_dut1"}, 32'(n1), 32'd256);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy0"},  32'(if0.busy), 32'd1);
      chk({tag, "_busy1"},  32'(if1.busy), 32'd1);
      chk({tag, "_douta0"}, if0.dout_a, 32'd0);
      chk({tag, "_doutb0"}, if0.dout_b, 32'd0);
      chk({tag, "_douta1"}, if1.dout_a, 32'd0);
      chk({tag, "_doutb1"}, if1.dout_b, 32'd0);
      chk({tag, "_vld0"},   32'({if0.dout_vld_a, if0.dout_vld_b}), 32'd0);
      chk({tag, "_vld1"},   32'({if1.dout_vld_a, if1.dout_vld_b}), 32'd0);
      chk({tag, "_coll"},   32'({if0.collision, if1.collision}), 32'd0);
      chk({tag, "_dbg0"},   if0.dbg_rdata, 32'd0);
      chk({tag, "_dbg1"},   if1.dbg_rdata, 32'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      set_a(0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0);
      set_misc(0, 0);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      idle(2);
      rst_n = 1'b1;
      wait_clear("init_clear_len");

      // Zero reads after the initial clear, pipelined one per cycle
      set_a(1, 0, 0, 0, 0);   set_b(1, 0, 0, 0, 0); push_rd(0, 0, 0); push_rd(1, 0, 0); tick();
      set_a(1, 0, 0, 128, 0); set_b(0, 0, 0, 0, 0); push_rd(0, 0, 0); tick();
      set_a(1, 0, 0, 255, 0); push_rd(0, 0, 0); tick();
      set_a(0, 0, 0, 0, 0);
      idle(4);

      // Write then read back, with a concurrent read of address 0
      set_a(1, 1, 5, 0, 32'h11); push_rd(0, 0, 0); tick();
      set_a(1, 0, 0, 5, 0); push_rd(0, 32'h11, 32'h11); tick();
      set_a(0, 0, 0, 0, 0);
      idle(4);

      // Write collision on address 7, where both ports also read address 7 on the same edge
      set_a(1, 1, 7, 7, 32'hAAAA); push_rd(0, 0, 32'hAAAA);
      set_b(1, 1, 7, 7, 32'hBBBB); push_rd(1, 0, 32'hAAAA);
      tick();
      chk("collision_dut0", 32'(if0.collision), 32'd1);
      chk("collision_dut1", 32'(if1.collision), 32'd1);
      set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
      tick();
      chk("collision_clr_dut0", 32'(if0.collision), 32'd0);
      chk("collision_clr_dut1", 32'(if1.collision), 32'd0);
      set_a(1, 0, 0, 7, 0); push_rd(0, 32'hAAAA, 32'hAAAA); tick();
      set_a(0, 0, 0, 0, 0);
      idle(4);

      // Cross-port read-during-write on address 9, observed through port B and the debug port
      set_a(1, 1, 9, 0, 32'h1); push_rd(0, 0, 0); tick();
      set_a(1, 1, 9, 0, 32'h2); push_rd(0, 0, 0);
      set_b(1, 0, 0, 9, 0); push_rd(1, 32'h1, 32'h2);
      set_misc(0, 9);
      tick();
      chk("dbg_rdw_dut0", if0.dbg_rdata, 32'h1);
      chk("dbg_rdw_dut1", if1.dbg_rdata, 32'h2);
      set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
      tick();
      chk("dbg_after_dut0", if0.dbg_rdata, 32'h2);
      chk("dbg_after_dut1", if1.dbg_rdata, 32'h2);
      idle(3);

      // Fill 0..3 with 1..4 (each edge also reads the address being written), then clear
      for (int i = 0; i < 4; i++) begin
         set_a(1, 1, 8'(i), 8'(i), 32'(i + 1));
         push_rd(0, 0, 32'(i + 1));
         tick();
      end
      set_a(1, 0, 0, 3, 0); push_rd(0, 32'd4, 32'd4);
      set_misc(1, 2);
      tick();
      set_misc(0, 2);
      chk("clr_busy_dut0", 32'(if0.busy), 32'd1);
      chk("clr_busy_dut1", 32'(if1.busy), 32'd1);
      set_a(1, 1, 2, 2, 32'h55);
      wait_clear("req_clear_len");
      set_a(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         set_a(1, 0, 0, 8'(i), 0); push_rd(0, 0, 0); tick();
      end
      set_a(0, 0, 0, 0, 0);
      idle(4);

      // Reset while reads are in flight
      set_a(1, 1, 5, 5, 32'h33); push_rd(0, 0, 32'h33); tick();
      set_a(1, 0, 0, 5, 0); push_rd(0, 32'h33, 32'h33); tick();
      set_a(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1 check_reset_outputs("reset_mid_read");
      exp_q[2].delete(); due_q[2].delete();
      rst_n = 1'b1;
      wait_clear("mid_read_clear_len");

      // Reset partway through a requested clear
      set_a(1, 1, 5, 0, 32'h44); push_rd(0, 0, 0); tick();
      set_a(0, 0, 0, 0, 0);
      set_misc(1, 5); tick(); set_misc(0, 5);
      idle(100);
      rst_n = 1'b0;
      #1 check_reset_outputs("reset_mid_clear");
      rst_n = 1'b1;
      wait_clear("mid_clear_len");
      set_a(1, 0, 0, 5, 0); push_rd(0, 0, 0); tick();
      set_a(0, 0, 0, 0, 0);
      idle(4);
      chk("dbg_addr5_dut0", if0.dbg_rdata, 32'd0);
      chk("dbg_addr5_dut1", if1.dbg_rdata, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/coeff_bram_mp.md
Name: coeff_bram_mp

Overview:
- Parametrised dual-port coefficient RAM for the NTT datapath and the next generation of the existing two-port BRAM.
- Adds configurable read latency, a read-enable gated valid pipeline, and defined read-during-write and write-collision behaviour.
- Includes a hardware clear sequencer that replaces per-word async reset of the array, plus a registered debug read port in place of the flattened memory bus.
- Sits between the NTT controller/butterfly units and polynomial storage.

Parameters:
- DEPTH, 256, number of words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- WIDTH, 32, word width.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-cycle read/write to one address: 0 = old data, 1 = new data (write-first).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clr_req  in  1  start clear sequence; one-cycle pulse, sampled when not busy.
- busy  out  1  clear sequence in progress.
- en_a  in  1  port A access enable (read and write).
- we_a  in  1  port A write enable.
- waddr_a  in  ADDR_WIDTH  port A write address.
- raddr_a  in  ADDR_WIDTH  port A read address.
- din_a  in  WIDTH  port A write data.
- dout_a  out  WIDTH  port A read data.
- dout_vld_a  out  1  port A read data valid.
- en_b, we_b, waddr_b, raddr_b, din_b, dout_b, dout_vld_b: same as port A, for port B.
- collision  out  1  pulse when both ports wrote the same address.
- dbg_raddr  in  ADDR_WIDTH  debug read address.
- dbg_rdata  out  WIDTH  debug read data, registered, 1-cycle latency.

Behaviour:
- Reset (async): FSM to CLR, clear pointer = 0, busy = 1. dout_a/b = 0, dout_vld_a/b = 0, collision = 0, dbg_rdata = 0. Array contents are not reset directly.
- FSM states are IDLE and CLR.
  - In CLR, each edge writes 0 to mem[ptr] and increments ptr. The edge that writes DEPTH-1 moves to IDLE, and busy = 0 after that edge.
  - After reset release, edges 1..DEPTH clear addresses 0..DEPTH-1, so busy falls after edge DEPTH (256 by default).
- clr_req sampled high in IDLE at edge k:
  - busy = 1 after edge k.
  - Edges k+1..k+DEPTH clear the array.
  - Port accesses presented at edge k execute normally.
- clr_req while busy is ignored.
- While busy:
  - Port writes are dropped.
  - Port reads are not issued; dout holds its value and dout_vld stays 0.
  - The debug port still works.
- Access in IDLE:
  - Write when en_x & we_x.
  - Read every cycle en_x = 1, regardless of we_x. dout_x updates RD_LAT edges later, and dout_vld_x = 1 for exactly that one cycle.
  - With en_x = 0, dout_x holds and dout_vld_x = 0.
  - Back-to-back reads give one result per cycle (fully pipelined).
- RD_LAT = 2 adds one output register stage: the stage-1 data and valid are pipelined identically. Reads already in flight when clr_req is sampled complete normally.
- Write collision: both ports write the same address at the same edge.
  - Port A data is stored.
  - collision = 1 for the cycle after that edge; otherwise collision = 0.
  - Different addresses: both writes occur.
- Read-during-write: a read address equals a write address at the same edge.
  - RDW_MODE = 0: the read returns pre-write contents.
  - RDW_MODE = 1: the read returns the stored (priority-resolved) write data.
  - This applies across ports (A read vs B write) and within a port.
- The debug read is not gated by en_x and also obeys RDW_MODE. The clear write counts as a write for RDW purposes.
- Reset mid-clear or mid-read: pipelines flush to 0 and the clear restarts from address 0.

Test Plan:
- Release reset, hold ports idle: busy = 1 for 256 edges, then 0. Read addresses 0, 128, 255 → dout = 0 with dout_vld pulses.
- After clear, A writes 0x00000011 to addr 5; next cycle A reads addr 5 → dout_a = 0x11 with dout_vld_a = 1 exactly RD_LAT edges after the read (check RD_LAT = 1 and RD_LAT = 2).
- A writes 0xAAAA and B writes 0xBBBB to addr 7 at the same edge → collision = 1 for one cycle; later read of 7 → 0xAAAA.
- Addr 9 holds 0x1; A writes 0x2 to addr 9 while B reads 9 at the same edge → dout_b = 0x1 with RDW_MODE = 0, 0x2 with RDW_MODE = 1.
- Fill addrs 0..3 with 1..4, pulse clr_req, attempt A write 0x55 to addr 2 during busy → busy high 256 cycles, dout_vld stays 0; afterwards addrs 0..3 read 0.
- Assert rst_n low mid-clear (pointer ≈100) and mid-read: outputs go to 0 immediately; after release the full 256-cycle clear repeats.
